// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the immediate-extension stage: opcodes, format
// codes, instruction field positions and skid-buffer states.
package imm_extend_stage_pkg;

   // Opcode constants (instruction bits [31:25])
   localparam logic [6:0] OP_LDB  = 7'h10;
   localparam logic [6:0] OP_LDW  = 7'h11;
   localparam logic [6:0] OP_STB  = 7'h12;
   localparam logic [6:0] OP_STW  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h30;
   localparam logic [6:0] OP_JUMP = 7'h31;
   localparam logic [6:0] OP_ORI  = 7'h04;
   localparam logic [6:0] OP_ANDI = 7'h05;

   // Format codes presented on out_fmt
   typedef enum logic [2:0] {
      FMT_NONE   = 3'd0,
      FMT_LOAD   = 3'd1,
      FMT_STORE  = 3'd2,
      FMT_BRANCH = 3'd3,
      FMT_JUMP   = 3'd4,
      FMT_ZEXT   = 3'd5
   } fmt_e;

   // Instruction field bit ranges
   localparam int OP_HI     = 31;
   localparam int OP_LO     = 25;
   localparam int OFFHI_HI  = 24;
   localparam int OFFHI_LO  = 20;
   localparam int OFFMID_HI = 14;
   localparam int OFFMID_LO = 10;
   localparam int OFFLO_HI  = 9;
   localparam int OFFLO_LO  = 0;

   // Occupancy of the output + skid register pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // Only branches and jumps carry a PC-relative target
   function automatic logic is_pcrel(input logic [2:0] fmt);
      return (fmt == FMT_BRANCH) || (fmt == FMT_JUMP);
   endfunction

endpackage

// File: rtl/imm_extend_stage_decode.sv
// Combinational instruction -> {format, extended immediate} decoder.
module imm_field_decode
   import imm_extend_stage_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic [2:0]             fmt,
   output logic [DATA_WIDTH-1:0]  imm
);

   logic [6:0] op;
   logic [4:0] offhi;
   logic [4:0] offmid;
   logic [9:0] offlo;
   logic       unused_bits;

   assign op     = instr[OP_HI:OP_LO];
   assign offhi  = instr[OFFHI_HI:OFFHI_LO];
   assign offmid = instr[OFFMID_HI:OFFMID_LO];
   assign offlo  = instr[OFFLO_HI:OFFLO_LO];
   // Bits [19:15] carry no immediate information
   assign unused_bits = ^instr[19:15];

   function automatic logic [DATA_WIDTH-1:0] sext15(input logic signed [14:0] v);
      logic signed [DATA_WIDTH-1:0] r;
      r = v;
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sext20(input logic signed [19:0] v);
      logic signed [DATA_WIDTH-1:0] r;
      r = v;
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] zext15(input logic [14:0] v);
      return {{(DATA_WIDTH-15){1'b0}}, v};
   endfunction

   // Classify by opcode group and build the extended immediate
   always_comb begin
      fmt = FMT_NONE;
      imm = {{(DATA_WIDTH-10){1'b0}}, offlo};
      case (op)
         OP_LDB, OP_LDW: begin
            fmt = FMT_LOAD;
            imm = sext15({offmid, offlo});
         end
         OP_STB, OP_STW: begin
            fmt = FMT_STORE;
            imm = sext15({offhi, offlo});
         end
         OP_BEQ: begin
            fmt = FMT_BRANCH;
            imm = sext15({offhi, offlo});
         end
         OP_JUMP: begin
            fmt = FMT_JUMP;
            imm = sext20({offhi, offmid, offlo});
         end
         OP_ORI, OP_ANDI: begin
            fmt = FMT_ZEXT;
            imm = zext15({offmid, offlo});
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Pipelined immediate generation with PC-relative target and a two-entry
// skid buffer (output register + skid register) under valid/ready control.
module imm_extend_stage
   import imm_extend_stage_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int INSTR_WIDTH  = 32,
   parameter int BRANCH_SHIFT = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic [DATA_WIDTH-1:0]  in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_imm,
   output logic [DATA_WIDTH-1:0]  out_target,
   output logic [2:0]             out_fmt
);

   // ---- stage p0: decode and target add on the input side ----
   logic [2:0]            dec_fmt_p0;
   logic [DATA_WIDTH-1:0] dec_imm_p0;
   logic [DATA_WIDTH-1:0] dec_off_p0;
   logic [DATA_WIDTH-1:0] dec_tgt_p0;

   imm_field_decode #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_decode (
      .instr (in_instr),
      .fmt   (dec_fmt_p0),
      .imm   (dec_imm_p0)
   );

   assign dec_off_p0 = dec_imm_p0 << BRANCH_SHIFT;
   assign dec_tgt_p0 = is_pcrel(dec_fmt_p0) ? (in_pc + dec_off_p0) : '0;

   // ---- stage p1: output register and skid register ----
   state_e                state, state_nxt;
   logic                  accept;
   logic                  load_out, load_skid, from_skid;
   logic [2:0]            out_fmt_p1, skid_fmt_p1;
   logic [DATA_WIDTH-1:0] out_imm_p1, skid_imm_p1;
   logic [DATA_WIDTH-1:0] out_tgt_p1, skid_tgt_p1;

   // Acceptance depends only on registered state, never on out_ready
   assign accept = in_valid && (state != ST_FULL) && !flush;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   // Next-state logic; flush overrides every other event
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
               if (accept && !out_ready)      state_nxt = ST_FULL;
               else if (!accept && out_ready) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (out_ready) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs and register load controls
   always_comb begin
      in_ready  = (state != ST_FULL);
      out_valid = (state != ST_EMPTY);
      load_out  = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      if (!flush) begin
         case (state)
            ST_EMPTY: load_out = accept;
            ST_ONE: begin
               if (accept) begin
                  if (out_ready) load_out  = 1'b1;
                  else           load_skid = 1'b1;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  load_out  = 1'b1;
                  from_skid = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Data registers change only on load; flush leaves their contents alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_fmt_p1  <= '0;
         out_imm_p1  <= '0;
         out_tgt_p1  <= '0;
         skid_fmt_p1 <= '0;
         skid_imm_p1 <= '0;
         skid_tgt_p1 <= '0;
      end else begin
         if (load_skid) begin
            skid_fmt_p1 <= dec_fmt_p0;
            skid_imm_p1 <= dec_imm_p0;
            skid_tgt_p1 <= dec_tgt_p0;
         end
         if (load_out) begin
            out_fmt_p1 <= from_skid ? skid_fmt_p1 : dec_fmt_p0;
            out_imm_p1 <= from_skid ? skid_imm_p1 : dec_imm_p0;
            out_tgt_p1 <= from_skid ? skid_tgt_p1 : dec_tgt_p0;
         end
      end
   end

   assign out_fmt    = out_fmt_p1;
   assign out_imm    = out_imm_p1;
   assign out_target = out_tgt_p1;

endmodule
